// File: rtl/mux_scan_ctrl_if.sv
// Stream and control bundle between the scan controller and its environment
// (mux select/data path, start/mask control, captured-sample handshake).
interface mux_scan_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 8,
   parameter int SEL_W = 3
);
   logic             start;
   logic             continuous;
   logic [NCH-1:0]   ch_mask;
   logic [SEL_W-1:0] Sel;
   logic [WIDTH-1:0] mux_out;
   logic [WIDTH-1:0] data;
   logic [SEL_W-1:0] ch_id;
   logic             valid;
   logic             ready;
   logic             busy;
   logic             done;

   modport master (
      input  start, continuous, ch_mask, mux_out, ready,
      output Sel, data, ch_id, valid, busy, done
   );

   modport slave (
      output start, continuous, ch_mask, mux_out, ready,
      input  Sel, data, ch_id, valid, busy, done
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through the enabled channels in ascending order, waits
// SETTLE cycles per channel, then offers the sample and its channel on valid/ready.
module mux_scan_ctrl #(
   parameter int WIDTH  = 8,
   parameter int NCH    = 8,
   parameter int SEL_W  = $clog2(NCH),
   parameter int SETTLE = 2
) (
   input logic             clk,
   input logic             rst_n,
   mux_scan_ctrl_if.master bus
);

   localparam int PTR_W = SEL_W + 1;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEEK,
      S_SETTLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [SEL_W-1:0] r_sel;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_ch_id;
   logic             r_valid;
   logic [PTR_W-1:0] r_ptr;
   logic [NCH-1:0]   r_mask_q;
   logic [CNT_W-1:0] r_cnt;

   state_t           w_next;
   logic             w_found;
   logic [SEL_W-1:0] w_hit_idx;
   logic             w_load_pass;
   logic             w_seek_hit;
   logic             w_cnt_dec;
   logic             w_capture;
   logic             w_accept;
   logic             w_busy;
   logic             w_done;

   // Priority search: iterating downwards lets the lowest qualifying channel win.
   // The pointer is one bit wider than Sel, so ptr == NCH matches nothing.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_found   = 1'b0;
      w_hit_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (r_mask_q[i] && (PTR_W'(i) >= r_ptr)) begin
            w_found   = 1'b1;
            w_hit_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      w_load_pass = 1'b0;
      w_seek_hit  = 1'b0;
      w_cnt_dec   = 1'b0;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) begin
               w_load_pass = 1'b1;
               w_next      = S_SEEK;
            end
         end
         S_SEEK: begin
            if (w_found) begin
               w_seek_hit = 1'b1;
               w_next     = S_SETTLE;
            end else begin
               w_next = S_DONE;
            end
         end
         S_SETTLE: begin
            if (r_cnt != '0) begin
               w_cnt_dec = 1'b1;
            end else begin
               w_capture = 1'b1;
               w_next    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_valid && bus.ready) begin
               w_accept = 1'b1;
               w_next   = (r_ch_id == SEL_W'(NCH - 1)) ? S_DONE : S_SEEK;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            if (bus.continuous) begin
               w_load_pass = 1'b1;
               w_next      = S_SEEK;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sel    <= '0;
         r_data   <= '0;
         r_ch_id  <= '0;
         r_valid  <= 1'b0;
         r_ptr    <= '0;
         r_mask_q <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         if (w_load_pass) begin
            r_mask_q <= bus.ch_mask;
            r_ptr    <= '0;
         end
         // Counter preload of SETTLE-1 plus the capture cycle gives SETTLE edges of settle time.
         if (w_seek_hit) begin
            r_sel <= w_hit_idx;
            r_cnt <= CNT_W'(SETTLE - 1);
         end
         if (w_cnt_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_capture) begin
            r_data  <= bus.mux_out;
            r_ch_id <= r_sel;
            r_valid <= 1'b1;
         end
         if (w_accept) begin
            r_valid <= 1'b0;
            r_ptr   <= {1'b0, r_ch_id} + PTR_W'(1);
         end
      end
   end

   assign bus.Sel   = r_sel;
   assign bus.data  = r_data;
   assign bus.ch_id = r_ch_id;
   assign bus.valid = r_valid;
   assign bus.busy  = w_busy;
   assign bus.done  = w_done;

endmodule
